exmemory: RTL and testbench

EXMEMORY -- requirements
Module: exmemory

---
 rtl/exmemory_pkg.sv | 27 ++
 rtl/exmemory_hex_display.sv | 53 +++++
 rtl/exmemory.sv | 116 +++++++++++
 tb/tb_exmemory.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/exmemory_pkg.sv
// Shared encodings for the exmemory block: access sizes, I/O register map
// and the byte-lane enable helper used by the RAM write path.
package exmemory_pkg;

    typedef enum logic [1:0] {
        MODE_WORD     = 2'b00,
        MODE_HALF     = 2'b01,
        MODE_BYTE     = 2'b10,
        MODE_WORD_ALT = 2'b11
    } mem_mode_e;

    localparam logic [15:0] IO_BASE = 16'hFF00;
    localparam logic [15:0] IO_SW   = 16'hFF00;
    localparam logic [15:0] IO_BTN  = 16'hFF04;
    localparam logic [15:0] IO_LED  = 16'hFF08;
    localparam logic [15:0] IO_DISP = 16'hFF0C;

    // Little-endian lane selection: bit i enables byte i of the addressed word.
    function automatic logic [3:0] byte_enables(input mem_mode_e mode, input logic [1:0] offset);
        case (mode)
            MODE_HALF: return offset[1] ? 4'b1100 : 4'b0011;
            MODE_BYTE: return 4'b0001 << offset;
            default:   return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/exmemory_hex_display.sv
// Four-digit multiplexed 7-segment driver: free-running refresh counter,
// digit select from its top two bits, active-low hex segment decode.
module hex_display #(
    parameter int REFRESH_BITS = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] value,
    output logic [3:0]  disp_sel,
    output logic [7:0]  disp_dig
);

    logic [REFRESH_BITS-1:0] refresh;
    logic [1:0]              digit;
    logic [3:0]              nibble;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            refresh <= '0;
        end else begin
            refresh <= refresh + 1'b1;
        end
    end

    assign digit    = refresh[REFRESH_BITS-1 -: 2];
    assign nibble   = value[4*digit +: 4];
    assign disp_sel = ~(4'b0001 << digit);

    // Segment order {dp,g,f,e,d,c,b,a}, all active-low; dp stays dark.
    always_comb begin
        disp_dig = 8'hFF;
        case (nibble)
            4'h0: disp_dig = 8'hC0;
            4'h1: disp_dig = 8'hF9;
            4'h2: disp_dig = 8'hA4;
            4'h3: disp_dig = 8'hB0;
            4'h4: disp_dig = 8'h99;
            4'h5: disp_dig = 8'h92;
            4'h6: disp_dig = 8'h82;
            4'h7: disp_dig = 8'hF8;
            4'h8: disp_dig = 8'h80;
            4'h9: disp_dig = 8'h90;
            4'hA: disp_dig = 8'h88;
            4'hB: disp_dig = 8'h83;
            4'hC: disp_dig = 8'hC6;
            4'hD: disp_dig = 8'hA1;
            4'hE: disp_dig = 8'h86;
            4'hF: disp_dig = 8'h8E;
            default: disp_dig = 8'hFF;
        endcase
    end

endmodule

// File: rtl/exmemory.sv
// CPU data memory: little-endian word RAM with byte/half/word access and a
// small memory-mapped I/O page (switches, button latches, LEDs, hex display).
module exmemory
    import exmemory_pkg::*;
#(
    parameter int    RAM_WORDS    = 1024,
    parameter string INIT_FILE    = "mem.dat",
    parameter int    REFRESH_BITS = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [1:0]  MemMode,
    input  logic [15:0] memAddr,
    input  logic [31:0] writeMemData,
    input  logic [15:0] switches,
    input  logic        btn_u,
    input  logic        btn_d,
    input  logic        btn_l,
    input  logic        btn_r,
    output logic [15:0] leds,
    output logic [3:0]  disp_sel,
    output logic [7:0]  disp_dig,
    output logic [31:0] memData
);

    localparam int AW = $clog2(RAM_WORDS);

    logic [31:0]   ram [RAM_WORDS];
    logic [AW-1:0] ram_idx;
    mem_mode_e     mode;
    logic          is_io;
    logic [15:0]   io_reg;
    logic [3:0]    be;
    logic [31:0]   wlane;
    logic [31:0]   ram_word;
    logic [31:0]   ram_data;
    logic [31:0]   io_data;
    logic [15:0]   disp_value;
    logic [3:0]    btn_latch;
    logic [3:0]    btn_now;
    logic          btn_clr;

    assign mode    = mem_mode_e'(MemMode);
    assign ram_idx = AW'(32'(memAddr[15:2]) % RAM_WORDS);
    assign is_io   = (memAddr[15:8] == IO_BASE[15:8]);
    assign io_reg  = {memAddr[15:2], 2'b00};
    assign be      = byte_enables(mode, memAddr[1:0]);

    always_comb begin
        wlane = writeMemData;
        case (mode)
            MODE_HALF: wlane = {2{writeMemData[15:0]}};
            MODE_BYTE: wlane = {4{writeMemData[7:0]}};
            default:   wlane = writeMemData;
        endcase
    end

    always_ff @(posedge clk) begin
        if (MemWrite && !is_io) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) ram[ram_idx][8*i +: 8] <= wlane[8*i +: 8];
            end
        end
    end

    assign btn_now = {btn_u, btn_d, btn_l, btn_r};
    assign btn_clr = MemWrite && is_io && (io_reg == IO_BTN);

    // A press in the same cycle as a clearing write leaves its bit set.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            leds       <= '0;
            disp_value <= '0;
            btn_latch  <= '0;
        end else begin
            if (MemWrite && is_io && io_reg == IO_LED)  leds       <= writeMemData[15:0];
            if (MemWrite && is_io && io_reg == IO_DISP) disp_value <= writeMemData[15:0];
            btn_latch <= (btn_clr ? 4'b0000 : btn_latch) | btn_now;
        end
    end

    always_comb begin
        ram_word = ram[ram_idx];
        ram_data = ram_word;
        case (mode)
            MODE_HALF: ram_data = {16'h0, memAddr[1] ? ram_word[31:16] : ram_word[15:0]};
            MODE_BYTE: ram_data = {24'h0, ram_word[8*memAddr[1:0] +: 8]};
            default:   ram_data = ram_word;
        endcase
    end

    always_comb begin
        io_data = 32'h0;
        case (io_reg)
            IO_SW:   io_data = {16'h0, switches};
            IO_BTN:  io_data = {28'h0, btn_latch};
            IO_LED:  io_data = {16'h0, leds};
            IO_DISP: io_data = {16'h0, disp_value};
            default: io_data = 32'h0;
        endcase
    end

    assign memData = is_io ? io_data : ram_data;

    hex_display #(
        .REFRESH_BITS(REFRESH_BITS)
    ) u_hex_display (
        .clk      (clk),
        .reset    (reset),
        .value    (disp_value),
        .disp_sel (disp_sel),
        .disp_dig (disp_dig)
    );

endmodule

// File: tb/tb_exmemory.sv
// Directed and randomized checks of exmemory against a byte-array memory model.
module tb_exmemory;
    import exmemory_pkg::*;

    localparam int RW = 64;
    localparam int RB = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemWrite;
    logic [1:0]  MemMode;
    logic [15:0] memAddr;
    logic [31:0] writeMemData;
    logic [15:0] switches;
    logic        btn_u, btn_d, btn_l, btn_r;
    logic [15:0] leds;
    logic [3:0]  disp_sel;
    logic [7:0]  disp_dig;
    logic [31:0] memData;

    int compared = 0;
    int mismatched = 0;

    logic [7:0] mem_m [RW*4];
    logic [7:0] seg_ref [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    exmemory #(.RAM_WORDS(RW), .INIT_FILE(""), .REFRESH_BITS(RB)) dut (
        .clk(clk), .reset(reset), .MemWrite(MemWrite), .MemMode(MemMode),
        .memAddr(memAddr), .writeMemData(writeMemData), .switches(switches),
        .btn_u(btn_u), .btn_d(btn_d), .btn_l(btn_l), .btn_r(btn_r),
        .leds(leds), .disp_sel(disp_sel), .disp_dig(disp_dig), .memData(memData)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int base_of(input logic [15:0] a);
        return ((int'(a) / 4) % RW) * 4;
    endfunction

    task automatic model_write(input logic [15:0] a, input logic [1:0] m, input logic [31:0] d);
        int base, off, n;
        base = base_of(a);
        if (m == 2'b01)      begin off = 2 * int'(a[1]); n = 2; end
        else if (m == 2'b10) begin off = int'(a[1:0]);   n = 1; end
        else                 begin off = 0;              n = 4; end
        for (int k = 0; k < n; k++) mem_m[base + off + k] = d[8*k +: 8];
    endtask

    function automatic logic [31:0] model_read(input logic [15:0] a, input logic [1:0] m);
        int base;
        logic [31:0] w;
        base = base_of(a);
        w = {mem_m[base+3], mem_m[base+2], mem_m[base+1], mem_m[base]};
        if (m == 2'b01) return (w >> (16 * int'(a[1]))) & 32'h0000FFFF;
        if (m == 2'b10) return (w >> (8 * int'(a[1:0]))) & 32'h000000FF;
        return w;
    endfunction

    task automatic do_write(input logic [15:0] a, input logic [1:0] m, input logic [31:0] d);
        @(negedge clk);
        memAddr = a; MemMode = m; writeMemData = d; MemWrite = 1'b1;
        @(posedge clk);
        #1 MemWrite = 1'b0;
        if (a < IO_BASE) model_write(a, m, d);
    endtask

    task automatic rd(input logic [15:0] a, input logic [1:0] m, output logic [31:0] v);
        memAddr = a; MemMode = m; MemWrite = 1'b0;
        #1 v = memData;
    endtask

    initial begin
        logic [31:0] v;
        logic [15:0] a;
        logic [1:0]  m;
        logic [31:0] d;
        int k, prev, changes;
        bit found;

        reset = 1'b0; MemWrite = 1'b0; MemMode = 2'b00; memAddr = 16'h0;
        writeMemData = 32'h0; switches = 16'h0;
        btn_u = 1'b0; btn_d = 1'b0; btn_l = 1'b0; btn_r = 1'b0;
        #12;
        chk("rst_leds", {16'h0, leds}, 32'h0);
        chk("rst_sel", {28'h0, disp_sel}, 32'hE);
        chk("rst_dig", {24'h0, disp_dig}, 32'hC0);
        rd(IO_BTN, 2'b00, v);  chk("rst_btn", v, 32'h0);
        rd(IO_DISP, 2'b00, v); chk("rst_disp", v, 32'h0);
        @(negedge clk); reset = 1'b1;

        for (int i = 0; i < RW; i++) do_write(16'(4*i), 2'b00, $urandom);

        do_write(16'h0010, 2'b00, 32'hDEADBEEF);
        rd(16'h0010, 2'b00, v); chk("word_rd", v, 32'hDEADBEEF);
        rd(16'h0011, 2'b10, v); chk("byte_rd", v, 32'h000000BE);
        rd(16'h0012, 2'b01, v); chk("half_rd", v, 32'h0000DEAD);
        rd(16'h0013, 2'b11, v); chk("mode3_rd", v, 32'hDEADBEEF);
        do_write(16'h0013, 2'b10, 32'hFFFFFF55);
        rd(16'h0010, 2'b00, v); chk("byte_wr", v, 32'h55ADBEEF);
        do_write(16'h0011, 2'b01, 32'hAAAA1234);
        rd(16'h0010, 2'b00, v); chk("half_wr_lo", v, 32'h55AD1234);

        // MemWrite low across an edge must leave RAM alone
        @(negedge clk);
        memAddr = 16'h0010; MemMode = 2'b00; writeMemData = 32'h0BAD0BAD; MemWrite = 1'b0;
        @(posedge clk); #1;
        rd(16'h0010, 2'b00, v); chk("no_we", v, 32'h55AD1234);

        // aliasing modulo RAM_WORDS
        rd(16'(16'h0010 + 4*RW), 2'b00, v); chk("alias", v, 32'h55AD1234);

        switches = 16'hBEEF;
        rd(IO_SW, 2'b00, v); chk("switches", v, 32'h0000BEEF);
        switches = 16'h1357;
        rd(16'hFF02, 2'b10, v); chk("switches_b", v, 32'h00001357);

        @(negedge clk); btn_u = 1'b1;
        @(negedge clk); btn_u = 1'b0; btn_d = 1'b1;
        @(negedge clk); btn_d = 1'b0;
        rd(IO_BTN, 2'b00, v); chk("btn_ud", v, 32'h0000000C);
        do_write(IO_BTN, 2'b00, 32'h0);
        rd(IO_BTN, 2'b00, v); chk("btn_clr", v, 32'h0);
        @(negedge clk); btn_l = 1'b1; memAddr = IO_BTN; MemWrite = 1'b1;
        @(negedge clk); btn_l = 1'b0; MemWrite = 1'b0;
        rd(IO_BTN, 2'b00, v); chk("btn_setwins", v, 32'h00000002);

        do_write(IO_LED, 2'b00, 32'hFFFF1234);
        do_write(IO_DISP, 2'b10, 32'h00001234);
        chk("leds", {16'h0, leds}, 32'h1234);
        rd(16'hFF0A, 2'b10, v); chk("led_rd", v, 32'h00001234);
        rd(IO_DISP, 2'b00, v); chk("disp_rd", v, 32'h00001234);
        do_write(16'hFF10, 2'b00, 32'h0000FFFF);
        rd(16'hFF10, 2'b00, v); chk("unmapped", v, 32'h0);
        chk("leds_kept", {16'h0, leds}, 32'h1234);

        prev = -1; changes = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            found = 1'b0; k = 0;
            for (int j = 0; j < 4; j++) if (disp_sel == ~(4'b0001 << j)) begin found = 1'b1; k = j; end
            chk("sel_onehot", {31'h0, found}, 32'h1);
            chk("dig", {24'h0, disp_dig}, {24'h0, seg_ref[(16'h1234 >> (4*k)) & 16'hF]});
            if (prev >= 0 && k != prev) begin
                chk("sel_order", k, (prev + 1) % 4);
                changes++;
            end
            prev = k;
        end
        chk("sel_changes", {31'h0, changes >= 3}, 32'h1);

        for (int i = 0; i < 150; i++) begin
            a = 16'($urandom_range(0, 16'hFEFF));
            m = 2'($urandom_range(0, 3));
            d = $urandom;
            if ($urandom_range(0, 1) == 1) begin
                do_write(a, m, d);
            end else begin
                rd(a, m, v);
                chk($sformatf("rand_rd_%0d", i), v, model_read(a, m));
            end
        end

        @(negedge clk); btn_r = 1'b1;
        @(negedge clk); btn_r = 1'b0;
        do_write(IO_DISP, 2'b00, 32'h5A5A);
        #3 reset = 1'b0;
        #1;
        chk("mid_rst_leds", {16'h0, leds}, 32'h0);
        chk("mid_rst_sel", {28'h0, disp_sel}, 32'hE);
        chk("mid_rst_dig", {24'h0, disp_dig}, 32'hC0);
        rd(IO_BTN, 2'b00, v);  chk("mid_rst_btn", v, 32'h0);
        rd(IO_DISP, 2'b00, v); chk("mid_rst_disp", v, 32'h0);
        rd(16'h0010, 2'b00, v); chk("mid_rst_ram", v, model_read(16'h0010, 2'b00));
        @(negedge clk); reset = 1'b1;
        do_write(IO_LED, 2'b00, 32'h0000C0DE);
        chk("post_rst_leds", {16'h0, leds}, 32'hC0DE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
